// File: rtl/ex_mem_pipe.sv
// EX/MEM pipeline register with valid/ready handshake, flush,
// optional two-entry skid and a saturating stall counter.
module ex_mem_pipe #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int OP_W   = 8,
  parameter int SKID   = 0,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              ex_valid,
  output logic              ex_ready,
  input  logic [ADDR_W-1:0] ex_wd,
  input  logic              ex_wreg,
  input  logic [DATA_W-1:0] ex_wdata,
  input  logic              ex_whilo,
  input  logic [DATA_W-1:0] ex_hi,
  input  logic [DATA_W-1:0] ex_lo,
  input  logic [OP_W-1:0]   ex_aluop,
  output logic              mem_valid,
  input  logic              mem_ready,
  output logic [ADDR_W-1:0] mem_wd,
  output logic              mem_wreg,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_whilo,
  output logic [DATA_W-1:0] mem_hi,
  output logic [DATA_W-1:0] mem_lo,
  output logic [OP_W-1:0]   mem_aluop,
  output logic [CNT_W-1:0]  stall_cnt
);

  typedef struct packed {
    logic [ADDR_W-1:0] wd;
    logic              wreg;
    logic [DATA_W-1:0] wdata;
    logic              whilo;
    logic [DATA_W-1:0] hi;
    logic [DATA_W-1:0] lo;
    logic [OP_W-1:0]   aluop;
  } ent_t;

  ent_t in_e;
  ent_t main_q;
  ent_t skid_q;
  logic skid_valid;
  logic accept;
  logic drain;

  assign in_e = '{
    wd:    ex_wd,
    wreg:  ex_wreg,
    wdata: ex_wdata,
    whilo: ex_whilo,
    hi:    ex_hi,
    lo:    ex_lo,
    aluop: ex_aluop
  };

  // Skid mode only looks at held state, so mem_ready never reaches ex_ready.
  always_comb begin
    if (SKID != 0) ex_ready = rst && !skid_valid;
    else           ex_ready = rst && (!mem_valid || mem_ready);
  end

  assign accept = ex_valid && ex_ready;
  assign drain  = mem_valid && mem_ready;

  always_ff @(posedge clk) begin
    if (!rst || flush) begin
      mem_valid  <= 1'b0;
      main_q     <= '0;
      skid_valid <= 1'b0;
      skid_q     <= '0;
    end else if (SKID == 0) begin
      if (accept) begin
        main_q    <= in_e;
        mem_valid <= 1'b1;
      end else if (drain) begin
        main_q    <= '0;
        mem_valid <= 1'b0;
      end
    end else begin
      if (drain) begin
        if (skid_valid) begin
          main_q     <= skid_q;
          skid_valid <= 1'b0;
          skid_q     <= '0;
        end else if (accept) begin
          main_q <= in_e;
        end else begin
          main_q    <= '0;
          mem_valid <= 1'b0;
        end
      end else if (accept) begin
        if (mem_valid) begin
          skid_q     <= in_e;
          skid_valid <= 1'b1;
        end else begin
          main_q    <= in_e;
          mem_valid <= 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      stall_cnt <= '0;
    end else if (mem_valid && !mem_ready && stall_cnt != '1) begin
      stall_cnt <= stall_cnt + 1'b1;
    end
  end

  assign mem_wd    = main_q.wd;
  assign mem_wreg  = main_q.wreg;
  assign mem_wdata = main_q.wdata;
  assign mem_whilo = main_q.whilo;
  assign mem_hi    = main_q.hi;
  assign mem_lo    = main_q.lo;
  assign mem_aluop = main_q.aluop;

endmodule

// File: tb/tb_ex_mem_pipe.sv
// Scoreboard bench for ex_mem_pipe: dut0 is SKID=0/CNT_W=4,
// dut1 is SKID=1/CNT_W=16.
module tb_ex_mem_pipe;

  typedef struct packed {
    logic [4:0]  wd;
    logic        wreg;
    logic [31:0] wdata;
    logic        whilo;
    logic [31:0] hi;
    logic [31:0] lo;
    logic [7:0]  aluop;
  } pl_t;

  logic clk = 0;
  logic rst = 0;
  logic flush = 0;
  pl_t  in_pl = '0;

  logic v0 = 0, r0 = 0, rdy0, mv0;
  logic v1 = 0, r1 = 0, rdy1, mv1;
  pl_t  o0, o1;
  logic [3:0]  sc0;
  logic [15:0] sc1;

  int tests = 0;
  int fails = 0;
  pl_t q0[$];
  pl_t q1[$];

  always #5 clk = ~clk;

  ex_mem_pipe #(.SKID(0), .CNT_W(4)) dut0 (
    .clk(clk), .rst(rst), .flush(flush),
    .ex_valid(v0), .ex_ready(rdy0),
    .ex_wd(in_pl.wd), .ex_wreg(in_pl.wreg),
    .ex_wdata(in_pl.wdata), .ex_whilo(in_pl.whilo),
    .ex_hi(in_pl.hi), .ex_lo(in_pl.lo),
    .ex_aluop(in_pl.aluop),
    .mem_valid(mv0), .mem_ready(r0),
    .mem_wd(o0.wd), .mem_wreg(o0.wreg),
    .mem_wdata(o0.wdata), .mem_whilo(o0.whilo),
    .mem_hi(o0.hi), .mem_lo(o0.lo),
    .mem_aluop(o0.aluop), .stall_cnt(sc0)
  );

  ex_mem_pipe #(.SKID(1), .CNT_W(16)) dut1 (
    .clk(clk), .rst(rst), .flush(flush),
    .ex_valid(v1), .ex_ready(rdy1),
    .ex_wd(in_pl.wd), .ex_wreg(in_pl.wreg),
    .ex_wdata(in_pl.wdata), .ex_whilo(in_pl.whilo),
    .ex_hi(in_pl.hi), .ex_lo(in_pl.lo),
    .ex_aluop(in_pl.aluop),
    .mem_valid(mv1), .mem_ready(r1),
    .mem_wd(o1.wd), .mem_wreg(o1.wreg),
    .mem_wdata(o1.wdata), .mem_whilo(o1.whilo),
    .mem_hi(o1.hi), .mem_lo(o1.lo),
    .mem_aluop(o1.aluop), .stall_cnt(sc1)
  );

  task automatic chk(input string n,
                     input logic [127:0] a,
                     input logic [127:0] e);
    tests++;
    if (a !== e) begin
      fails++;
      $display("FAIL %s: got %h expected %h", n, a, e);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_pl(input logic [31:0] d);
    in_pl = '{wd: 5'd3, wreg: 1'b1, wdata: d,
              whilo: d[0], hi: ~d, lo: d + 32'd1,
              aluop: d[7:0] ^ 8'h5a};
  endtask

  // Monitors: pop on every handshake, enforce the zero-payload rule.
  always @(negedge clk) begin
    if (mv0 && r0) begin
      if (q0.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL dut0 spurious: got %h expected none", o0);
      end else begin
        chk("dut0 payload", o0, q0.pop_front());
      end
    end
    if (!mv0) chk("dut0 idle payload", o0, '0);
    if (!rst) chk("dut0 ready in reset", rdy0, 0);
    if (!rst || flush) q0.delete();
    else if (v0 && rdy0) q0.push_back(in_pl);
  end

  always @(negedge clk) begin
    if (mv1 && r1) begin
      if (q1.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL dut1 spurious: got %h expected none", o1);
      end else begin
        chk("dut1 payload", o1, q1.pop_front());
      end
    end
    if (!mv1) chk("dut1 idle payload", o1, '0);
    if (!rst) chk("dut1 ready in reset", rdy1, 0);
    if (!rst || flush) q1.delete();
    else if (v1 && rdy1) q1.push_back(in_pl);
  end

  logic [31:0] sv [4] = '{32'h11, 32'h22, 32'h33, 32'h44};
  logic [15:0] s;

  initial begin
    step();
    step();
    chk("reset mv0", mv0, 0);
    chk("reset mv1", mv1, 0);
    chk("reset sc0", sc0, 0);
    chk("reset sc1", sc1, 0);
    chk("reset rdy0", rdy0, 0);
    chk("reset rdy1", rdy1, 0);
    rst = 1;
    #1;
    chk("rdy0 after reset", rdy0, 1);
    chk("rdy1 after reset", rdy1, 1);

    // Streaming, SKID=0
    r0 = 1;
    v0 = 1;
    for (int i = 0; i < 4; i++) begin
      set_pl(sv[i]);
      chk("stream rdy0", rdy0, 1);
      step();
      chk("stream mv0", mv0, 1);
      chk("stream wdata0", o0.wdata, sv[i]);
    end
    v0 = 0;
    step();
    chk("stream end mv0", mv0, 0);
    step();
    chk("stream idle mv0", mv0, 0);
    chk("stream sc0", sc0, 0);

    // Saturation, CNT_W=4
    r0 = 0;
    v0 = 1;
    set_pl(32'h55);
    step();
    v0 = 0;
    for (int k = 1; k <= 20; k++) begin
      step();
      chk("sat sc0", sc0, (k < 15) ? k : 15);
      chk("sat rdy0", rdy0, 0);
    end
    r0 = 1;
    step();
    chk("sat drain mv0", mv0, 0);
    chk("sat hold sc0", sc0, 15);
    r0 = 0;

    // Stall, SKID=1
    r1 = 0;
    v1 = 1;
    set_pl(32'hA);
    step();
    chk("stall rdy1 a", rdy1, 1);
    chk("stall sc1 a", sc1, 0);
    set_pl(32'hB);
    step();
    v1 = 0;
    chk("stall rdy1 b", rdy1, 0);
    chk("stall wdata1 b", o1.wdata, 32'hA);
    chk("stall sc1 b", sc1, 1);
    for (int k = 2; k <= 4; k++) begin
      step();
      chk("stall sc1", sc1, k);
      chk("stall rdy1", rdy1, 0);
      chk("stall wdata1", o1.wdata, 32'hA);
    end
    r1 = 1;
    step();
    chk("unstall wdata1", o1.wdata, 32'hB);
    chk("unstall rdy1", rdy1, 1);
    chk("unstall sc1", sc1, 4);
    step();
    chk("unstall mv1", mv1, 0);

    // Flush with both entries full
    r1 = 0;
    v1 = 1;
    set_pl(32'hC);
    step();
    set_pl(32'hD);
    step();
    chk("flush full rdy1", rdy1, 0);
    s = sc1;
    flush = 1;
    r1 = 1;
    set_pl(32'hE);
    step();
    flush = 0;
    v1 = 0;
    chk("flush mv1", mv1, 0);
    chk("flush wreg1", o1.wreg, 0);
    chk("flush wdata1", o1.wdata, 0);
    chk("flush sc1", sc1, s);
    chk("flush rdy1", rdy1, 1);
    step();
    step();
    chk("flush no ghost mv1", mv1, 0);

    // Flush discarding a same-cycle accept
    r1 = 0;
    v1 = 1;
    set_pl(32'hF);
    step();
    s = sc1;
    flush = 1;
    r1 = 1;
    set_pl(32'h10);
    chk("flush acc rdy1", rdy1, 1);
    step();
    flush = 0;
    v1 = 0;
    chk("flush acc mv1", mv1, 0);
    chk("flush acc sc1", sc1, s);
    step();
    chk("flush acc ghost mv1", mv1, 0);

    // Mid-operation reset
    r1 = 0;
    v1 = 1;
    set_pl(32'h21);
    step();
    set_pl(32'h22);
    step();
    rst = 0;
    set_pl(32'h23);
    #1;
    chk("rst rdy1 comb", rdy1, 0);
    step();
    chk("rst mv1", mv1, 0);
    chk("rst wdata1", o1.wdata, 0);
    chk("rst sc1", sc1, 0);
    chk("rst rdy1", rdy1, 0);
    chk("rst sc0", sc0, 0);
    rst = 1;
    r1 = 1;
    set_pl(32'h24);
    #1;
    chk("post rst rdy1", rdy1, 1);
    step();
    v1 = 0;
    chk("post rst mv1", mv1, 1);
    chk("post rst wdata1", o1.wdata, 32'h24);
    step();
    chk("post rst drain mv1", mv1, 0);

    step();
    chk("q0 empty", q0.size(), 0);
    chk("q1 empty", q1.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
